pwm_ramp_scheduler: RTL

Sequencer for the 16-bit PWM compare word (PWM_CW) driving the launcher servo PWM controller. It accepts target-duty commands over a valid/ready handshake and ramps PWM_CW toward the target by a programmable step. Updates happen once per PWM period, only at the period boundary, so the PWM controller never sees a mid-period change. It sits between the NIOS-facing command registers and the PWM controller's PWM_CW input.

---
 rtl/pwm_sched_pkg.sv | 15 +
 rtl/pwm_period_timer.sv | 24 ++
 rtl/pwm_ramp_scheduler.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pwm_sched_pkg.sv
// Shared types and default constants for the PWM compare-word ramp scheduler.
package pwm_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam int CW_WIDTH_D   = 16;
    localparam int PERIOD_MAX_D = 62500;
    localparam int RESET_CW_D   = 4688;
    localparam int MIN_CW_D     = 3125;
    localparam int MAX_CW_D     = 6250;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running 0..PERIOD_MAX counter; period_tick marks the last cycle of each period.
module pwm_period_timer #(
    parameter int PERIOD_MAX = 62500
) (
    input  logic clk,
    input  logic rst,
    output logic period_tick
);

    localparam int CNT_W = $clog2(PERIOD_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last      = (r_cnt == CNT_W'(PERIOD_MAX));
    assign period_tick = w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (w_last) r_cnt <= '0;
        else             r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Ramps PWM_CW toward a commanded target, one step per PWM period at the period boundary.
// Define PWM_RAMP_LIMIT_EN to clamp accepted targets to [MIN_CW, MAX_CW].
module pwm_ramp_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CW_WIDTH   = CW_WIDTH_D,
    parameter int PERIOD_MAX = PERIOD_MAX_D,
    parameter int RESET_CW   = RESET_CW_D,
    parameter int MIN_CW     = MIN_CW_D,
    parameter int MAX_CW     = MAX_CW_D
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CW_WIDTH-1:0] cmd_target,
    input  logic [CW_WIDTH-1:0] cmd_step,
    output logic [CW_WIDTH-1:0] PWM_CW,
    output logic                period_tick,
    output logic                busy,
    output logic                done,
    output logic                clamp_flag
);

    state_t              r_state, w_state_nxt;
    logic [CW_WIDTH-1:0] r_cw, w_cw_nxt;
    logic [CW_WIDTH-1:0] r_target, w_target_nxt;
    logic [CW_WIDTH-1:0] r_step, w_step_nxt;
    logic                r_done, w_done_nxt;
    logic                r_clamp, w_clamp_nxt;
    logic                w_tick;
    logic [CW_WIDTH-1:0] w_tgt_in;
    logic                w_clamp_in;
    logic [CW_WIDTH:0]   w_diff;

    pwm_period_timer #(.PERIOD_MAX(PERIOD_MAX)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .period_tick (w_tick)
    );

`ifdef PWM_RAMP_LIMIT_EN
    always_comb begin
        w_tgt_in   = cmd_target;
        w_clamp_in = 1'b0;
        if (cmd_target < CW_WIDTH'(MIN_CW)) begin
            w_tgt_in   = CW_WIDTH'(MIN_CW);
            w_clamp_in = 1'b1;
        end else if (cmd_target > CW_WIDTH'(MAX_CW)) begin
            w_tgt_in   = CW_WIDTH'(MAX_CW);
            w_clamp_in = 1'b1;
        end
    end
`else
    logic [CW_WIDTH-1:0] w_unused_lim;
    assign w_unused_lim = CW_WIDTH'(MIN_CW) ^ CW_WIDTH'(MAX_CW);
    assign w_tgt_in     = cmd_target;
    assign w_clamp_in   = 1'b0;
`endif

    // One extra bit keeps the distance exact across the full compare-word range.
    assign w_diff = (r_target >= r_cw) ? ({1'b0, r_target} - {1'b0, r_cw})
                                       : ({1'b0, r_cw} - {1'b0, r_target});

    always_comb begin
        w_state_nxt  = r_state;
        w_cw_nxt     = r_cw;
        w_target_nxt = r_target;
        w_step_nxt   = r_step;
        w_clamp_nxt  = r_clamp;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_target_nxt = w_tgt_in;
                    w_step_nxt   = cmd_step;
                    w_clamp_nxt  = w_clamp_in;
                    w_state_nxt  = RAMP;
                end
            end
            RAMP: begin
                if (w_tick) begin
                    if (r_step == '0 || w_diff <= {1'b0, r_step}) begin
                        w_cw_nxt    = r_target;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (r_target > r_cw) begin
                        w_cw_nxt = r_cw + r_step;
                    end else begin
                        w_cw_nxt = r_cw - r_step;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cw     <= CW_WIDTH'(RESET_CW);
            r_target <= '0;
            r_step   <= '0;
            r_done   <= 1'b0;
            r_clamp  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cw     <= w_cw_nxt;
            r_target <= w_target_nxt;
            r_step   <= w_step_nxt;
            r_done   <= w_done_nxt;
            r_clamp  <= w_clamp_nxt;
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state == RAMP);
    assign done        = r_done;
    assign PWM_CW      = r_cw;
    assign period_tick = w_tick;
    assign clamp_flag  = r_clamp;

endmodule
